cpu_trace_monitor: RTL and testbench
====================================

Name: cpu_trace_monitor

Overview:
Synthesizable writeback-trace monitor for the pipelined MIPS32 CPU. Snoops the register-file write port and fetch PC, then buffers {pc, reg, data} commit records in a parametrised FIFO. It adds PC-match triggering, halt (PC-stall) detection and overflow flagging. A ready/valid read port drains the buffer to a bench or debug host.

Parameters:
DATA_W, 32, register data width
PC_W, 32, program counter width
REG_W, 5, register index width
DEPTH, 16, trace FIFO entries; power of two, >=2
STALL_LIMIT, 8, consecutive cycles of unchanged fetch PC that declare halt; >=2
STOP_ON_FULL, 0, 1 = go to DONE when FIFO fills; 0 = keep running, drop new records, flag overflow

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high; clears all state
arm  in  1  one-cycle pulse; IDLE->ARMED
trig_en  in  1  1 = wait for trig_pc match; 0 = start capture immediately on arm
trig_pc  in  PC_W  trigger address
pc_in  in  PC_W  fetch PC (halt detection, trigger compare)
wb_we  in  1  register-file write enable
wb_reg  in  REG_W  write register index
wb_data  in  DATA_W  write data
wb_pc  in  PC_W  PC of committing instruction
rd_valid  out  1  head record available
rd_ready  in  1  consumer accepts head
rd_pc  out  PC_W  head record PC
rd_reg  out  REG_W  head record register
rd_data  out  DATA_W  head record data
count  out  $clog2(DEPTH+1)  entries held
overflow  out  1  sticky: a record was dropped
halted  out  1  sticky: halt detected
state  out  2  IDLE=0, ARMED=1, CAPTURE=2, DONE=3

Behaviour:
- Reset (synchronous, active-high): state=IDLE, count=0, rd_valid=0, rd_pc/rd_reg/rd_data=0, overflow=0, halted=0, stall counter=0, pointers=0. Reset while capturing discards all records.
- IDLE: arm -> ARMED. If trig_en=0, arm goes straight to CAPTURE.
- ARMED: pc_in==trig_pc -> CAPTURE in the next cycle. The record from that same cycle's wb is not captured.
- CAPTURE: each cycle with wb_we=1 and wb_reg!=0 pushes {wb_pc, wb_reg, wb_data}. Writes to $zero are ignored.
- DONE: no pushes. The FIFO still drains. arm in DONE -> ARMED (or CAPTURE if trig_en=0) and clears overflow and halted. Records are not cleared.
- Arm in ARMED or CAPTURE is ignored.
- Halt detect runs in ARMED and CAPTURE:
  - Stall counter increments when pc_in equals the previous cycle's pc_in; otherwise it resets to 0.
  - When it reaches STALL_LIMIT-1: halted=1 and state->DONE on the next edge.
- FIFO:
  - Push and pop are registered; latency push->rd_valid is 1 cycle.
  - Pop occurs when rd_valid && rd_ready.
  - rd_* present the head record combinationally from storage and are 0 when empty.
- Full:
  - A push is accepted when count<DEPTH, or when count==DEPTH and a pop occurs in the same cycle (count unchanged).
  - Otherwise the record is dropped and overflow=1.
  - With STOP_ON_FULL=1, reaching count==DEPTH moves state to DONE on the next edge.
- Simultaneous push and pop on empty: count->1, rd_valid=1 next cycle. Pop is not possible, since rd_valid=0.
- Pointers are log2(DEPTH) bits wide and wrap naturally. count = pushes - pops.

Decomposition:
- Shared package cpu_trace_pkg holds:
  - state encodings ST_IDLE, ST_ARMED, ST_CAPTURE, ST_DONE;
  - the trace record struct/width constant (PC_W+REG_W+DATA_W);
  - the $zero register index constant.
- One sub-module is natural: trace_fifo, a synchronous FIFO parametrised by WIDTH and DEPTH with push, pop, full, empty, count.
- Control FSM and halt detector stay in cpu_trace_monitor.

Test Plan:
- Reset mid-capture: 5 records pushed, reset high 1 cycle -> count=0, rd_valid=0, state=0, overflow=0, halted=0.
- Immediate capture: arm with trig_en=0; writes ($t0=0x5 @pc 0x04), ($zero=0x9 @0x08), ($s1=0xA @0x0C) -> exactly 2 records read in order: {0x04,8,0x5}, {0x0C,17,0xA}.
- Trigger: trig_en=1, trig_pc=0x20; PC steps by 4 from 0 with a write each cycle -> first captured record has wb_pc from the cycle after pc_in==0x20; nothing captured earlier.
- Overflow: DEPTH=16, STOP_ON_FULL=0, 20 writes, rd_ready=0 -> count=16, overflow=1, drained records are the first 16. Repeat with STOP_ON_FULL=1 -> state=3 after 16th push.
- Full with simultaneous pop: count=16, rd_ready=1 and a write in the same cycle -> count stays 16, overflow stays 0, new record at tail.
- Halt: pc_in held at 0x3C for 8 cycles (STALL_LIMIT=8) -> halted=1 and state=3 after the 8th equal cycle; re-arm clears halted.

Source files
------------

// File: rtl/cpu_trace_pkg.sv
// rtl/cpu_trace_pkg.sv - shared state encodings and trace record helpers for the writeback monitor
package cpu_trace_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_DONE    = 2'd3
   } trace_state_t;

   localparam int ZERO_REG = 0;

   // A record is packed {pc, reg, data}, pc in the most significant bits.
   function automatic int rec_width(input int pc_w, input int reg_w, input int data_w);
      return pc_w + reg_w + data_w;
   endfunction

endpackage

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - synchronous FIFO; a push into a full FIFO is taken only alongside a pop
module trace_fifo #(
   parameter int WIDTH = 69,
   parameter int DEPTH = 16,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [WIDTH-1:0] i_wdata,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_full,
   output logic             o_empty,
   output logic [CW-1:0]    o_count
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_pop;
   logic             w_push;

   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign w_pop   = i_pop && !o_empty;
   assign w_push  = i_push && (!o_full || w_pop);
   assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr];

   always_ff @(posedge i_clock) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_wdata;
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end

endmodule

// File: rtl/cpu_trace_monitor.sv
// rtl/cpu_trace_monitor.sv - writeback trace monitor: arm/trigger FSM, halt detector, record FIFO
module cpu_trace_monitor
   import cpu_trace_pkg::*;
#(
   parameter int DATA_W       = 32,
   parameter int PC_W         = 32,
   parameter int REG_W        = 5,
   parameter int DEPTH        = 16,
   parameter int STALL_LIMIT  = 8,
   parameter int STOP_ON_FULL = 0
) (
   input  logic                       i_clock,
   input  logic                       i_reset,
   input  logic                       i_arm,
   input  logic                       i_trig_en,
   input  logic [PC_W-1:0]            i_trig_pc,
   input  logic [PC_W-1:0]            i_pc_in,
   input  logic                       i_wb_we,
   input  logic [REG_W-1:0]           i_wb_reg,
   input  logic [DATA_W-1:0]          i_wb_data,
   input  logic [PC_W-1:0]            i_wb_pc,
   output logic                       o_rd_valid,
   input  logic                       i_rd_ready,
   output logic [PC_W-1:0]            o_rd_pc,
   output logic [REG_W-1:0]           o_rd_reg,
   output logic [DATA_W-1:0]          o_rd_data,
   output logic [$clog2(DEPTH+1)-1:0] o_count,
   output logic                       o_overflow,
   output logic                       o_halted,
   output logic [1:0]                 o_state
);

   localparam int REC_W = rec_width(PC_W, REG_W, DATA_W);
   localparam int SW    = $clog2(STALL_LIMIT);

   trace_state_t    r_state;
   logic [PC_W-1:0] r_prev_pc;
   logic [SW-1:0]   r_stall_cnt;
   logic            r_overflow;
   logic            r_halted;

   logic            w_active;
   logic            w_pc_same;
   logic            w_halt;
   logic            w_push_req;
   logic            w_pop;
   logic            w_full;
   logic            w_empty;
   logic [REC_W-1:0] w_rdata;
   trace_state_t    w_arm_state;

   assign w_active    = (r_state == ST_ARMED) || (r_state == ST_CAPTURE);
   assign w_pc_same   = (i_pc_in == r_prev_pc);
   // The counter holds equal cycles already seen; this one is the STALL_LIMIT-th.
   assign w_halt      = w_active && w_pc_same && (r_stall_cnt == SW'(STALL_LIMIT - 1));
   assign w_push_req  = (r_state == ST_CAPTURE) && i_wb_we && (i_wb_reg != REG_W'(ZERO_REG));
   assign w_pop       = !w_empty && i_rd_ready;
   assign w_arm_state = i_trig_en ? ST_ARMED : ST_CAPTURE;

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state     <= ST_IDLE;
         r_prev_pc   <= '0;
         r_stall_cnt <= '0;
         r_overflow  <= 1'b0;
         r_halted    <= 1'b0;
      end else begin
         r_prev_pc <= i_pc_in;
         if (!w_active || !w_pc_same) begin
            r_stall_cnt <= '0;
         end else if (r_stall_cnt != SW'(STALL_LIMIT - 1)) begin
            r_stall_cnt <= r_stall_cnt + SW'(1);
         end
         if (w_push_req && w_full && !w_pop) begin
            r_overflow <= 1'b1;
         end
         case (r_state)
            ST_IDLE: begin
               if (i_arm) begin
                  r_state <= w_arm_state;
               end
            end
            ST_ARMED: begin
               if (w_halt) begin
                  r_halted <= 1'b1;
                  r_state  <= ST_DONE;
               end else if (i_pc_in == i_trig_pc) begin
                  r_state <= ST_CAPTURE;
               end
            end
            ST_CAPTURE: begin
               if (w_halt) begin
                  r_halted <= 1'b1;
                  r_state  <= ST_DONE;
               end else if ((STOP_ON_FULL != 0) && w_full) begin
                  r_state <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (i_arm) begin
                  r_state    <= w_arm_state;
                  r_overflow <= 1'b0;
                  r_halted   <= 1'b0;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   trace_fifo #(
      .WIDTH (REC_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .i_clock (i_clock),
      .i_reset (i_reset),
      .i_push  (w_push_req),
      .i_pop   (i_rd_ready),
      .i_wdata ({i_wb_pc, i_wb_reg, i_wb_data}),
      .o_rdata (w_rdata),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (o_count)
   );

   assign {o_rd_pc, o_rd_reg, o_rd_data} = w_rdata;
   assign o_rd_valid = !w_empty;
   assign o_overflow = r_overflow;
   assign o_halted   = r_halted;
   assign o_state    = r_state;

endmodule

// File: tb/tb_cpu_trace_monitor.sv
// tb/tb_cpu_trace_monitor.sv - self-checking bench for cpu_trace_monitor against a queue-based model
module tb_cpu_trace_monitor;

   localparam int DEPTH       = 16;
   localparam int STALL_LIMIT = 8;
   localparam int REC_W       = 69;

   logic        clock;
   logic        reset;
   logic        arm;
   logic        trig_en;
   logic [31:0] trig_pc;
   logic [31:0] pc_in;
   logic        wb_we;
   logic [4:0]  wb_reg;
   logic [31:0] wb_data;
   logic [31:0] wb_pc;
   logic        rd_ready;

   logic        rd_valid;
   logic [31:0] rd_pc;
   logic [4:0]  rd_reg;
   logic [31:0] rd_data;
   logic [4:0]  count;
   logic        overflow;
   logic        halted;
   logic [1:0]  state;

   logic        s_rd_valid;
   logic [31:0] s_rd_pc;
   logic [4:0]  s_rd_reg;
   logic [31:0] s_rd_data;
   logic [2:0]  s_count;
   logic        s_overflow;
   logic        s_halted;
   logic [1:0]  s_state;

   int n_checks = 0;
   int n_fail   = 0;

   int               m_state;
   logic [REC_W-1:0] m_q[$];
   bit               m_ovf;
   bit               m_halt;
   int               m_run;
   logic [31:0]      m_prev_pc;

   int hold_left;
   int ready_pct;

   cpu_trace_monitor #(.DEPTH(DEPTH), .STALL_LIMIT(STALL_LIMIT), .STOP_ON_FULL(0)) u_dut (
      .i_clock(clock), .i_reset(reset), .i_arm(arm), .i_trig_en(trig_en), .i_trig_pc(trig_pc),
      .i_pc_in(pc_in), .i_wb_we(wb_we), .i_wb_reg(wb_reg), .i_wb_data(wb_data), .i_wb_pc(wb_pc),
      .o_rd_valid(rd_valid), .i_rd_ready(rd_ready), .o_rd_pc(rd_pc), .o_rd_reg(rd_reg),
      .o_rd_data(rd_data), .o_count(count), .o_overflow(overflow), .o_halted(halted), .o_state(state)
   );

   cpu_trace_monitor #(.DEPTH(4), .STALL_LIMIT(STALL_LIMIT), .STOP_ON_FULL(1)) u_dut_sof (
      .i_clock(clock), .i_reset(reset), .i_arm(arm), .i_trig_en(trig_en), .i_trig_pc(trig_pc),
      .i_pc_in(pc_in), .i_wb_we(wb_we), .i_wb_reg(wb_reg), .i_wb_data(wb_data), .i_wb_pc(wb_pc),
      .o_rd_valid(s_rd_valid), .i_rd_ready(rd_ready), .o_rd_pc(s_rd_pc), .o_rd_reg(s_rd_reg),
      .o_rd_data(s_rd_data), .o_count(s_count), .o_overflow(s_overflow), .o_halted(s_halted),
      .o_state(s_state)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // One clock: advance the model from the applied inputs, then compare after the edge.
   task automatic cyc();
      bit pop;
      bit push_req;
      bit full;
      bit halt_now;
      logic [REC_W-1:0] head;
      if (reset) begin
         m_state = 0;
         m_q.delete();
         m_ovf = 0;
         m_halt = 0;
         m_run = 0;
         m_prev_pc = '0;
      end else begin
         halt_now = 0;
         if ((m_state == 1 || m_state == 2) && pc_in == m_prev_pc) begin
            m_run++;
            halt_now = (m_run >= STALL_LIMIT);
         end else begin
            m_run = 0;
         end
         full     = (m_q.size() == DEPTH);
         pop      = (m_q.size() != 0) && rd_ready;
         push_req = (m_state == 2) && wb_we && (wb_reg != 5'd0);
         if (push_req && full && !pop) m_ovf = 1;
         case (m_state)
            0: if (arm) m_state = trig_en ? 1 : 2;
            1: begin
               if (halt_now) begin m_halt = 1; m_state = 3; end
               else if (pc_in == trig_pc) m_state = 2;
            end
            2: if (halt_now) begin m_halt = 1; m_state = 3; end
            default: begin
               if (arm) begin
                  m_state = trig_en ? 1 : 2;
                  m_ovf = 0;
                  m_halt = 0;
               end
            end
         endcase
         if (pop) void'(m_q.pop_front());
         if (push_req && (!full || pop)) m_q.push_back({wb_pc, wb_reg, wb_data});
         m_prev_pc = pc_in;
      end
      @(posedge clock);
      #1;
      head = (m_q.size() != 0) ? m_q[0] : '0;
      check("state", state, m_state);
      check("count", count, m_q.size());
      check("rd_valid", rd_valid, m_q.size() != 0);
      check("rd_pc", rd_pc, head[68:37]);
      check("rd_reg", rd_reg, head[36:32]);
      check("rd_data", rd_data, head[31:0]);
      check("overflow", overflow, m_ovf);
      check("halted", halted, m_halt);
   endtask

   task automatic tick();
      pc_in = pc_in + 32'd4;
      cyc();
   endtask

   task automatic do_reset();
      reset = 1; arm = 0; wb_we = 0; rd_ready = 0;
      cyc();
      reset = 0;
   endtask

   task automatic write(input logic [31:0] p, input logic [4:0] r, input logic [31:0] d);
      wb_we = 1; wb_pc = p; wb_reg = r; wb_data = d;
      tick();
      wb_we = 0;
   endtask

   initial begin
      arm = 0; trig_en = 0; trig_pc = '0; pc_in = 32'h100; wb_we = 0; wb_reg = '0;
      wb_data = '0; wb_pc = '0; rd_ready = 0;
      do_reset();
      check("rst_count", count, 0);
      check("rst_state", state, 0);

      // immediate capture, $zero write skipped
      arm = 1; trig_en = 0; tick(); arm = 0;
      write(32'h04, 5'd8, 32'h5);
      write(32'h08, 5'd0, 32'h9);
      write(32'h0C, 5'd17, 32'hA);
      check("imm_count", count, 2);
      check("imm_pc0", rd_pc, 32'h04);
      check("imm_reg0", rd_reg, 8);
      check("imm_data0", rd_data, 32'h5);
      rd_ready = 1; tick();
      check("imm_pc1", rd_pc, 32'h0C);
      check("imm_reg1", rd_reg, 17);
      check("imm_data1", rd_data, 32'hA);
      tick(); rd_ready = 0;
      check("imm_empty", rd_valid, 0);

      // reset mid-capture
      for (int i = 0; i < 5; i++) write(32'h40 + 32'(i) * 4, 5'(i + 1), 32'(i));
      check("mid_count", count, 5);
      do_reset();
      check("midrst_count", count, 0);
      check("midrst_valid", rd_valid, 0);
      check("midrst_state", state, 0);
      check("midrst_ovf", overflow, 0);
      check("midrst_halt", halted, 0);

      // PC trigger
      pc_in = 32'h200; trig_en = 1; trig_pc = 32'h20; arm = 1; cyc(); arm = 0;
      for (int k = 0; k < 16; k++) begin
         pc_in = 32'(k) * 4;
         wb_we = 1; wb_pc = pc_in; wb_reg = 5'd2; wb_data = 32'(k);
         cyc();
      end
      wb_we = 0;
      check("trig_first_pc", rd_pc, 32'h24);
      check("trig_count", count, 7);

      // overflow with rd_ready low; the second instance stops when full
      do_reset();
      arm = 1; trig_en = 0; tick(); arm = 0;
      for (int i = 0; i < 20; i++) begin
         write(32'h400 + 32'(i) * 4, 5'd3, 32'(i));
         if (i == 3) begin
            check("sof_count4", s_count, 4);
            check("sof_still_cap", s_state, 2);
         end
         if (i == 4) check("sof_done", s_state, 3);
      end
      check("ovf_count", count, 16);
      check("ovf_flag", overflow, 1);
      check("sof_count", s_count, 4);
      check("sof_ovf", s_overflow, 1);
      rd_ready = 1;
      for (int i = 0; i < 16; i++) begin
         check("ovf_drain", rd_data, 32'(i));
         tick();
      end
      rd_ready = 0;

      // full with simultaneous pop
      do_reset();
      arm = 1; trig_en = 0; tick(); arm = 0;
      for (int i = 0; i < 16; i++) write(32'h600 + 32'(i) * 4, 5'd4, 32'(i));
      rd_ready = 1;
      write(32'h700, 5'd5, 32'hBEEF);
      check("fullpop_count", count, 16);
      check("fullpop_ovf", overflow, 0);
      for (int i = 0; i < 15; i++) tick();
      check("fullpop_tail", rd_data, 32'hBEEF);
      tick();
      rd_ready = 0;

      // halt detection and re-arm
      do_reset();
      pc_in = 32'h38; arm = 1; trig_en = 0; cyc(); arm = 0;
      pc_in = 32'h3C; cyc();
      for (int e = 1; e <= 8; e++) begin
         cyc();
         if (e == 7) check("halt_early", halted, 0);
      end
      check("halt_flag", halted, 1);
      check("halt_state", state, 3);
      arm = 1; trig_en = 1; trig_pc = 32'h999; cyc(); arm = 0;
      check("rearm_halt", halted, 0);
      check("rearm_state", state, 1);
      for (int e = 0; e < 10; e++) cyc();

      // randomized traffic
      hold_left = 0;
      ready_pct = 50;
      for (int c = 0; c < 4000; c++) begin
         if (c % 256 == 0) ready_pct = ($urandom_range(0, 2) == 0) ? 10 : (($urandom_range(0, 1) == 0) ? 50 : 95);
         if (c % 64 == 0) trig_pc = 32'($urandom_range(0, 15)) * 4;
         reset   = ($urandom_range(0, 299) == 0);
         arm     = ($urandom_range(0, 19) == 0);
         trig_en = $urandom_range(0, 1);
         if (hold_left > 0) hold_left--;
         else if ($urandom_range(0, 39) == 0) hold_left = $urandom_range(4, 12);
         else pc_in = (pc_in + 32'd4) & 32'h3C;
         wb_we    = ($urandom_range(0, 9) < 6);
         wb_reg   = 5'($urandom_range(0, 3));
         wb_data  = $urandom;
         wb_pc    = pc_in;
         rd_ready = ($urandom_range(0, 99) < ready_pct);
         cyc();
      end
      reset = 0; arm = 0; wb_we = 0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
